// File: rtl/mem_access_stage.sv
// MEM stage of the RV64 pipeline: load/store over a req/gnt/rvalid data-memory port,
// branch resolution, upstream stall during multi-cycle accesses and the MEM/WB register.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned H/W/D accesses instead of
// silently aligning them down.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [63:0] pc_in,
    input  logic        zero_in,
    input  logic [63:0] alu_result_in,
    input  logic [63:0] read_data2_in,
    input  logic [4:0]  write_reg_in,
    input  logic [2:0]  mem_size_in,
    input  logic        branch_in,
    input  logic        memwrite_in,
    input  logic        memread_in,
    input  logic        memtoreg_in,
    input  logic        regwrite_in,
    output logic        stall_o,
    output logic        pcsrc_o,
    output logic [63:0] branch_target_o,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [63:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_regwrite,
    output logic        wb_memtoreg,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_alu_result,
    output logic [63:0] wb_load_data,
    output logic [1:0]  wb_exc
);

    localparam int unsigned CntW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

    typedef enum logic [1:0] {StIdle, StWaitGnt, StWaitRsp} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic        mem_op;
    logic        trap;
    logic        timeout_hit;
    logic        req_int;
    logic        complete;
    logic        abort;
    logic [2:0]  off;
    logic [7:0]  be_base;
    logic [63:0] shifted;
    logic [63:0] load_ext;

    assign mem_op          = in_valid & (memread_in | memwrite_in);
    assign pcsrc_o         = in_valid & branch_in & zero_in;
    assign branch_target_o = pc_in;
    assign dmem_addr       = {alu_result_in[63:3], 3'b000};
    // Gate with reset so the port drops the moment reset is asserted.
    assign dmem_req        = req_int & rst_n;
    assign dmem_we         = dmem_req & ~memread_in;
    assign timeout_hit     = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1));
    assign stall_o         = mem_op & ~complete;

`ifdef MISALIGN_TRAP_EN
    // Misaligned H/W/D access traps without touching memory.
    always_comb begin
        trap = 1'b0;
        unique case (mem_size_in[1:0])
            2'd0:    trap = 1'b0;
            2'd1:    trap = mem_op & alu_result_in[0];
            2'd2:    trap = mem_op & (|alu_result_in[1:0]);
            default: trap = mem_op & (|alu_result_in[2:0]);
        endcase
    end
`else
    assign trap = 1'b0;
`endif

    // Lane offset (low bits below the access size forced to zero), byte enables, write data.
    always_comb begin
        off        = alu_result_in[2:0];
        be_base    = 8'h01;
        dmem_wdata = read_data2_in;
        unique case (mem_size_in[1:0])
            2'd0: begin
                off        = alu_result_in[2:0];
                be_base    = 8'h01;
                dmem_wdata = {8{read_data2_in[7:0]}};
            end
            2'd1: begin
                off        = {alu_result_in[2:1], 1'b0};
                be_base    = 8'h03;
                dmem_wdata = {4{read_data2_in[15:0]}};
            end
            2'd2: begin
                off        = {alu_result_in[2], 2'b00};
                be_base    = 8'h0F;
                dmem_wdata = {2{read_data2_in[31:0]}};
            end
            default: begin
                off        = 3'd0;
                be_base    = 8'hFF;
                dmem_wdata = read_data2_in;
            end
        endcase
        dmem_be = be_base << off;
    end

    // Align the returned word to bit 0 and sign/zero extend.
    always_comb begin
        shifted = dmem_rdata >> {off, 3'b000};
        unique case (mem_size_in)
            3'b000:  load_ext = {{56{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{48{shifted[15]}}, shifted[15:0]};
            3'b010:  load_ext = {{32{shifted[31]}}, shifted[31:0]};
            3'b100:  load_ext = {56'd0, shifted[7:0]};
            3'b101:  load_ext = {48'd0, shifted[15:0]};
            3'b110:  load_ext = {32'd0, shifted[31:0]};
            default: load_ext = shifted;
        endcase
    end

    // Next state, request and completion decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_int  = 1'b0;
        complete = 1'b0;
        abort    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_op && !trap) begin
                    req_int = 1'b1;
                    cnt_d   = '0;
                    if (!dmem_gnt) begin
                        state_d = StWaitGnt;
                    end else if (memread_in) begin
                        state_d = StWaitRsp;
                    end else begin
                        complete = 1'b1;
                    end
                end else begin
                    // Non-memory op or trapped access finishes in one cycle.
                    complete = 1'b1;
                end
            end
            StWaitGnt: begin
                req_int = 1'b1;
                if (dmem_gnt) begin
                    cnt_d = '0;
                    if (memread_in) begin
                        state_d = StWaitRsp;
                    end else begin
                        complete = 1'b1;
                        state_d  = StIdle;
                    end
                end else if (timeout_hit) begin
                    abort    = 1'b1;
                    complete = 1'b1;
                    state_d  = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWaitRsp: begin
                if (dmem_rvalid) begin
                    complete = 1'b1;
                    state_d  = StIdle;
                end else if (timeout_hit) begin
                    abort    = 1'b1;
                    complete = 1'b1;
                    state_d  = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state and wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // MEM/WB register: loads on completion, otherwise inserts a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid      <= 1'b0;
            wb_regwrite   <= 1'b0;
            wb_memtoreg   <= 1'b0;
            wb_rd         <= '0;
            wb_alu_result <= '0;
            wb_load_data  <= '0;
            wb_exc        <= '0;
        end else if (complete) begin
            wb_valid      <= in_valid;
            wb_regwrite   <= in_valid & regwrite_in & ~abort & ~trap;
            wb_memtoreg   <= memtoreg_in;
            wb_rd         <= write_reg_in;
            wb_alu_result <= alu_result_in;
            wb_load_data  <= load_ext;
            wb_exc        <= {abort, trap};
        end else begin
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            wb_exc      <= '0;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: byte-level reference memory model, random
// grant/response latencies from a bench-side data memory, directed corner cases.
module tb_mem_access_stage;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, zero_in, branch_in, memwrite_in, memread_in, memtoreg_in, regwrite_in;
    logic [63:0] pc_in, alu_result_in, read_data2_in;
    logic [4:0]  write_reg_in;
    logic [2:0]  mem_size_in;
    logic        stall_o, pcsrc_o;
    logic [63:0] branch_target_o;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [7:0]  dmem_be;
    logic        wb_valid, wb_regwrite, wb_memtoreg;
    logic [4:0]  wb_rd;
    logic [63:0] wb_alu_result, wb_load_data;
    logic [1:0]  wb_exc;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .pc_in(pc_in), .zero_in(zero_in),
        .alu_result_in(alu_result_in), .read_data2_in(read_data2_in),
        .write_reg_in(write_reg_in), .mem_size_in(mem_size_in), .branch_in(branch_in),
        .memwrite_in(memwrite_in), .memread_in(memread_in), .memtoreg_in(memtoreg_in),
        .regwrite_in(regwrite_in), .stall_o(stall_o), .pcsrc_o(pcsrc_o),
        .branch_target_o(branch_target_o), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
        .wb_rd(wb_rd), .wb_alu_result(wb_alu_result), .wb_load_data(wb_load_data),
        .wb_exc(wb_exc)
    );

    typedef struct {
        logic        valid, mr, mw, br, zero, m2r, rw;
        logic [4:0]  rd;
        logic [2:0]  size;
        logic [63:0] addr, data, pc;
    } op_t;

    typedef struct {
        logic [4:0]  rd;
        logic        regwrite, memtoreg, chk_ld;
        logic [63:0] alu, ld;
        logic [1:0]  exc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    logic [7:0]  ref_mem [0:511];
    logic [63:0] dmem [0:63];

    // Responder controls, written by the stimulus before each instruction.
    int          gnt_dly = 0, rsp_dly = 0;
    bit          no_gnt = 0, no_rsp = 0, manual = 0;
    logic [63:0] exp_addr = '0;
    logic [7:0]  exp_be = '0;
    logic        exp_store = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Data memory: grants after gnt_dly requesting cycles, answers loads rsp_dly cycles later.
    initial begin
        bit          pending = 0;
        int          rsp_cnt = 0;
        int          gcnt = 0;
        logic [63:0] pend_data = '0;
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!manual) begin
                dmem_gnt = 1'b0;
                dmem_rvalid = 1'b0;
                if (!rst_n) begin
                    pending = 0;
                    gcnt = 0;
                end else begin
                    if (pending) begin
                        if (rsp_cnt == 0) begin
                            dmem_rvalid = 1'b1;
                            dmem_rdata = pend_data;
                            pending = 0;
                        end else begin
                            rsp_cnt--;
                        end
                    end
                    if (dmem_req && !no_gnt) begin
                        if (gcnt == gnt_dly) begin
                            dmem_gnt = 1'b1;
                            gcnt = 0;
                            check("dmem_addr", dmem_addr, exp_addr);
                            check("dmem_we", dmem_we, exp_store);
                            if (dmem_we) begin
                                check("dmem_be", dmem_be, exp_be);
                                for (int b = 0; b < 8; b++)
                                    if (dmem_be[b])
                                        dmem[dmem_addr[8:3]][8*b +: 8] = dmem_wdata[8*b +: 8];
                            end else if (!no_rsp) begin
                                pending = 1;
                                rsp_cnt = rsp_dly;
                                pend_data = dmem[dmem_addr[8:3]];
                            end
                        end else begin
                            gcnt++;
                        end
                    end
                end
            end
        end
    end

    // Monitor: every writeback is matched against the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && wb_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL wb_unexpected: got wb_valid=1 required no writeback");
                end else begin
                    e = exp_q.pop_front();
                    check("wb_rd", wb_rd, e.rd);
                    check("wb_regwrite", wb_regwrite, e.regwrite);
                    check("wb_memtoreg", wb_memtoreg, e.memtoreg);
                    check("wb_alu_result", wb_alu_result, e.alu);
                    check("wb_exc", wb_exc, e.exc);
                    if (e.chk_ld) check("wb_load_data", wb_load_data, e.ld);
                end
            end
        end
    end

    task automatic drive(input op_t op);
        in_valid = op.valid; memread_in = op.mr; memwrite_in = op.mw; branch_in = op.br;
        zero_in = op.zero; memtoreg_in = op.m2r; regwrite_in = op.rw; write_reg_in = op.rd;
        mem_size_in = op.size; alu_result_in = op.addr; read_data2_in = op.data; pc_in = op.pc;
    endtask

    // Called just after a rising edge; returns just after the completing edge.
    task automatic issue(input op_t op, input int gd, input int rsd, input bit ngnt,
                         input bit nrsp);
        exp_t        e;
        int          n, exp_cycles, cyc, idx;
        bit          memop, load, mis, trap, done;
        logic [63:0] eff, v;
        logic [15:0] bt;
        memop = op.valid && (op.mr || op.mw);
        load  = op.mr;
        n     = 1 << op.size[1:0];
        mis   = (op.addr % n) != 0;
        eff   = op.addr - (op.addr % n);
`ifdef MISALIGN_TRAP_EN
        trap = memop && mis;
`else
        trap = 0;
`endif
        e.rd = op.rd; e.regwrite = op.rw; e.memtoreg = op.m2r; e.alu = op.addr;
        e.chk_ld = 0; e.ld = '0; e.exc = 2'b00;
        if (!memop) begin
            exp_cycles = 1;
        end else if (trap) begin
            exp_cycles = 1; e.regwrite = 0; e.exc = 2'b01;
        end else if (ngnt) begin
            exp_cycles = 1 + TO; e.regwrite = 0; e.exc = 2'b10;
        end else if (!load) begin
            exp_cycles = gd + 1;
            for (int i = 0; i < n; i++) ref_mem[int'(eff[8:0]) + i] = 8'(op.data >> (8 * i));
        end else if (nrsp) begin
            exp_cycles = gd + 1 + TO; e.regwrite = 0; e.exc = 2'b10;
        end else begin
            exp_cycles = gd + 2 + rsd;
            v = '0;
            for (int i = 0; i < n; i++) begin
                idx = int'(eff[8:0]) + i;
                v = v | (64'(ref_mem[idx]) << (8 * i));
            end
            if (!op.size[2] && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
            e.ld = v; e.chk_ld = 1;
        end
        bt = ((16'd1 << n) - 16'd1) << eff[2:0];
        exp_be = bt[7:0];
        exp_addr = {eff[63:3], 3'b000};
        exp_store = !load;
        gnt_dly = gd; rsp_dly = rsd; no_gnt = ngnt; no_rsp = nrsp;
        if (op.valid) exp_q.push_back(e);
        drive(op);
        #1;
        check("pcsrc_o", pcsrc_o, op.valid & op.br & op.zero);
        check("branch_target_o", branch_target_o, op.pc);
        check("dmem_req_first", dmem_req, memop && !trap);
        cyc = 0;
        done = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            #1;
            cyc++;
            done = !stall_o;
        end
        check("cycles", cyc, exp_cycles);
        @(posedge clk);
        #1;
    endtask

    function automatic op_t mk(input bit mr, input bit mw, input logic [2:0] size,
                               input logic [63:0] addr, input logic [63:0] data,
                               input logic [4:0] rd);
        op_t o;
        o.valid = 1; o.mr = mr; o.mw = mw; o.br = 0; o.zero = 0; o.m2r = mr; o.rw = !mw || mr;
        o.rd = rd; o.size = size; o.addr = addr; o.data = data; o.pc = 64'h400;
        return o;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test required finish within 2 ms");
        $fatal(1);
    end

    initial begin
        op_t o;
        int  k;
        for (int i = 0; i < 512; i++) ref_mem[i] = 8'($urandom);
        for (int i = 0; i < 512; i++) dmem[i / 8][(i % 8) * 8 +: 8] = ref_mem[i];
        o = mk(0, 0, 3'd0, 64'd0, 64'd0, 5'd0);
        o.valid = 0;
        drive(o);
        #2;
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_dmem_req", dmem_req, 1'b0);
        check("rst_stall", stall_o, 1'b0);
        check("rst_wb_exc", wb_exc, 2'b00);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases.
        issue(mk(0, 0, 3'd0, 64'h1234, 64'd0, 5'd5), 0, 0, 0, 0);
        issue(mk(0, 1, 3'd0, 64'h1003, 64'h80, 5'd0), 0, 0, 0, 0);
        issue(mk(1, 0, 3'd0, 64'h1003, 64'd0, 5'd7), 0, 2, 0, 0);
        issue(mk(0, 1, 3'd1, 64'h2002, 64'hABCD, 5'd0), 4, 0, 0, 0);
        issue(mk(1, 0, 3'd1, 64'h2002, 64'd0, 5'd8), 1, 1, 0, 0);
        issue(mk(1, 0, 3'd5, 64'h2002, 64'd0, 5'd9), 0, 0, 0, 0);
        issue(mk(1, 0, 3'd2, 64'h3002, 64'd0, 5'd10), 0, 0, 0, 0);
        issue(mk(1, 0, 3'd3, 64'h3008, 64'd0, 5'd11), 0, 0, 1, 0);
        issue(mk(0, 1, 3'd3, 64'h3010, 64'h1, 5'd0), 0, 0, 1, 0);
        issue(mk(1, 0, 3'd6, 64'h3014, 64'd0, 5'd12), 2, 0, 0, 1);
        issue(mk(1, 1, 3'd4, 64'h3015, 64'd0, 5'd13), 0, 3, 0, 0);

        // Reset while waiting for a load response; a later stray rvalid must be ignored.
        o = mk(1, 0, 3'd3, 64'h1f0, 64'd0, 5'd14);
        gnt_dly = 0; no_gnt = 0; no_rsp = 1;
        exp_addr = 64'h1f0; exp_store = 1'b0;
        drive(o);
        repeat (2) @(negedge clk);
        #1;
        check("wait_rsp_stall", stall_o, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_async_req", dmem_req, 1'b0);
        check("rst_async_wb_valid", wb_valid, 1'b0);
        o.valid = 0;
        drive(o);
        @(posedge clk);
        #1 rst_n = 1'b1;
        manual = 1;
        @(negedge clk);
        dmem_rvalid = 1'b1;
        dmem_rdata = 64'hDEAD_BEEF;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        manual = 0;
        no_rsp = 0;
        repeat (3) @(negedge clk);
        check("post_rst_wb_valid", wb_valid, 1'b0);
        @(posedge clk);
        #1;

        // Random traffic.
        for (int t = 0; t < 160; t++) begin
            k = int'($urandom_range(0, 3));
            o = mk(k == 1 || k == 3, k == 2 || k == 3, 3'($urandom_range(0, 6)),
                   {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom));
            o.valid = ($urandom_range(0, 7) != 0);
            o.br = 1'($urandom); o.zero = 1'($urandom); o.m2r = 1'($urandom);
            o.rw = 1'($urandom); o.pc = {$urandom, $urandom};
            issue(o, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
        end

        o.valid = 0;
        drive(o);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
